// File: rtl/strap_sel_if.sv
// ---------------------------------------------------------------------------
// strap_sel_if
//   Bundles the strap-select controller's functional signals.
//
//   Signals (named from the controller's point of view):
//     ip_sel_i     [2:0] raw strap code from pads {pad2,pad1,pad0}
//     ip_sel_o     [2:0] accepted IP code, feeds the pad IO mux
//     sel_valid_o        ip_sel_o holds an accepted code
//     ip_rst_n_o   [7:0] per-IP active-low reset, bit n drives IP n
//     pad_oe_en_o        global enable for pad output drivers
//     sel_err_o          accepted code is not a populated IP
//     strap_chg_o        sticky: straps moved after acceptance
//     state_o      [2:0] controller FSM state, for debug/checkers
//
//   Modports:
//     slave  - the controller (drives the outputs, reads the straps)
//     master - whoever drives the straps and observes the result
//
//   Handshake: there is no valid/ready pair here. ip_sel_i is a level that
//   is sampled every clock; sel_valid_o is a level that, once high, stays
//   high with ip_sel_o frozen until the next reset.
// ---------------------------------------------------------------------------
interface strap_sel_if;
    logic [2:0] ip_sel_i;
    logic [2:0] ip_sel_o;
    logic       sel_valid_o;
    logic [7:0] ip_rst_n_o;
    logic       pad_oe_en_o;
    logic       sel_err_o;
    logic       strap_chg_o;
    logic [2:0] state_o;

    modport slave (
        input  ip_sel_i,
        output ip_sel_o,
        output sel_valid_o,
        output ip_rst_n_o,
        output pad_oe_en_o,
        output sel_err_o,
        output strap_chg_o,
        output state_o
    );

    modport master (
        output ip_sel_i,
        input  ip_sel_o,
        input  sel_valid_o,
        input  ip_rst_n_o,
        input  pad_oe_en_o,
        input  sel_err_o,
        input  strap_chg_o,
        input  state_o
    );
endinterface

// File: rtl/strap_sel_ctrl.sv
// ---------------------------------------------------------------------------
// strap_sel_ctrl
//   Boot-time strap selector. After reset release it waits SETTLE_CYC cycles
//   for the pads to settle, then waits for the 3-bit strap code to be stable
//   for STABLE_CYC consecutive comparisons, latches it, holds the selected IP
//   in reset for RST_HOLD_CYC cycles and finally releases that one IP and
//   enables the pad drivers. Codes not present in VALID_MASK park the block
//   in a terminal error state with every IP held in reset.
//   Once running, the straps keep being watched: a mismatch that persists
//   for STABLE_CYC cycles raises a sticky strap_chg_o flag without touching
//   the selection.
//
//   Ports:
//     sys_clk_i    sole clock, rising edge
//     sys_rst_n_i  asynchronous active-low reset
//     bus          strap_sel_if.slave (straps in, selection/resets out)
//
//   All outputs come straight from flops; there is no combinational path
//   from ip_sel_i to any output.
// ---------------------------------------------------------------------------
module strap_sel_ctrl #(
    parameter int unsigned    SETTLE_CYC   = 16,
    parameter int unsigned    STABLE_CYC   = 8,
    parameter int unsigned    RST_HOLD_CYC = 32,
    parameter logic [7:0]     VALID_MASK   = 8'b0010_1111
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_n_i,
    strap_sel_if.slave  bus
);

    // Terminal counts: each phase ends on the edge where cnt equals N-1.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYC - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(RST_HOLD_CYC - 1);

    typedef enum logic [2:0] {
        ST_SETTLE = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_HOLD   = 3'd2,
        ST_RUN    = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [2:0] prev_q,  prev_d;
    logic [2:0] sel_q,   sel_d;
    logic       valid_q, valid_d;
    logic [7:0] ip_rst_n_q, ip_rst_n_d;
    logic       pad_oe_q,   pad_oe_d;
    logic       err_q,      err_d;
    logic       chg_q,      chg_d;

    logic       strap_same;   // SAMPLE: current straps equal the previous sample
    logic       strap_moved;  // RUN: current straps differ from the accepted code

    assign strap_same  = (bus.ip_sel_i == prev_q);
    assign strap_moved = (bus.ip_sel_i != sel_q);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state_q    <= ST_SETTLE;
            cnt_q      <= 8'd0;
            prev_q     <= 3'd0;
            sel_q      <= 3'd0;
            valid_q    <= 1'b0;
            ip_rst_n_q <= 8'h00;
            pad_oe_q   <= 1'b0;
            err_q      <= 1'b0;
            chg_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            ip_rst_n_q <= ip_rst_n_d;
            pad_oe_q   <= pad_oe_d;
            err_q      <= err_d;
            chg_q      <= chg_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (strap_same && (cnt_q == STABLE_LAST)) begin
                    state_d = VALID_MASK[prev_q] ? ST_HOLD : ST_ERR;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_SETTLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / datapath next values. Everything holds unless the current
    // state says otherwise; that is what keeps ip_sel_o and sel_valid_o
    // frozen outside the acceptance edge.
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_d      = cnt_q;
        prev_d     = prev_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        ip_rst_n_d = ip_rst_n_q;
        pad_oe_d   = pad_oe_q;
        err_d      = err_q;
        chg_d      = chg_q;

        case (state_q)
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d  = 8'd0;
                    prev_d = bus.ip_sel_i;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_SAMPLE: begin
                if (strap_same) begin
                    if (cnt_q == STABLE_LAST) begin
                        cnt_d   = 8'd0;
                        sel_d   = prev_q;
                        valid_d = 1'b1;
                        err_d   = ~VALID_MASK[prev_q];
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    // A glitch only restarts the stability window.
                    cnt_d  = 8'd0;
                    prev_d = bus.ip_sel_i;
                end
            end

            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d      = 8'd0;
                    ip_rst_n_d = 8'h01 << sel_q;
                    pad_oe_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_RUN: begin
                // cnt now counts consecutive mismatching cycles; it saturates
                // so a long-lived mismatch can never wrap back to zero.
                if (strap_moved) begin
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    if (cnt_q == STABLE_LAST) begin
                        chg_d = 1'b1;
                    end
                end else begin
                    cnt_d = 8'd0;
                end
            end

            default: begin
                // ST_ERR is terminal: every register keeps its value.
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs (all register-driven)
    // -----------------------------------------------------------------------
    assign bus.ip_sel_o    = sel_q;
    assign bus.sel_valid_o = valid_q;
    assign bus.ip_rst_n_o  = ip_rst_n_q;
    assign bus.pad_oe_en_o = pad_oe_q;
    assign bus.sel_err_o   = err_q;
    assign bus.strap_chg_o = chg_q;
    assign bus.state_o     = state_q;

endmodule
